// File: rtl/adc_pkg.sv
// Shared definitions for the ADC read controller: FSM encoding and fixed levels.
package adc_pkg;

   // Controller phases, one per step of the conversion/readout sequence
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONV    = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      READ    = 3'd4,
      GAP     = 3'd5
   } state_t;

   // All ADC strobes are active-low, so their inactive level is 1
   localparam logic STROBE_IDLE = 1'b1;

   // Alternating pattern shown on the LEDs until the first sample arrives
   localparam logic [7:0] LED_RST_PATTERN = 8'h55;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving from outside the clk domain.
module sync_2ff #(
   parameter int W = 1
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_reg;
   logic [W-1:0] sync_reg;

   // Two-stage resampling; the first stage may go metastable, the second settles it
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/adc_reader.sv
// Conversion/readout controller for an 8-bit parallel ADC with a CONVST/BUSY/CS/RD bus.
// Every output comes straight from a register; the FSM computes next values combinationally.
module adc_reader
   import adc_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CONV_LOW_CYC = 4,
   parameter int RD_CYC       = 6,
   parameter int GAP_CYC      = 20,
   parameter int TIMEOUT_CYC  = 250,
   parameter int CNT_W        = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              auto_en,
   input  logic              ch_sel,
   output logic              AB,
   output logic              CONVST_n,
   output logic              CS_n,
   output logic              RD_n,
   input  logic              BUSY,
   input  logic [DATA_W-1:0] D_in,
   output logic [DATA_W-1:0] data,
   output logic              data_ch,
   output logic              valid,
   output logic              timeout_err,
   output logic [DATA_W-1:0] LED
);

   // Terminal counter values: a phase of N clocks ends when the counter shows N-1
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

   logic busy_s;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              convst_n_reg, convst_n_next;
   logic              rd_strobe_reg, rd_strobe_next;
   logic              ab_reg, ab_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic              data_ch_reg, data_ch_next;
   logic              valid_reg, valid_next;
   logic              timeout_reg, timeout_next;
   logic [DATA_W-1:0] led_reg, led_next;

   sync_2ff #(.W(1)) u_busy_sync (
      .clk (clk),
      .rst (rst),
      .d   (BUSY),
      .q   (busy_s)
   );

   // Next-state and next-output logic; every phase counter restarts at 0 on entry
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      convst_n_next  = convst_n_reg;
      rd_strobe_next = rd_strobe_reg;
      ab_next        = ab_reg;
      data_next      = data_reg;
      data_ch_next   = data_ch_reg;
      led_next       = led_reg;
      valid_next     = 1'b0;
      timeout_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            convst_n_next  = STROBE_IDLE;
            rd_strobe_next = STROBE_IDLE;
            if (start || auto_en) begin
               ab_next       = ch_sel;
               cnt_next      = '0;
               convst_n_next = ~STROBE_IDLE;
               state_next    = CONV;
            end
         end
         CONV: begin
            if (cnt_reg == CONV_LAST) begin
               convst_n_next = STROBE_IDLE;
               cnt_next      = '0;
               state_next    = WAIT_HI;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         WAIT_HI: begin
            if (busy_s) begin
               cnt_next   = '0;
               state_next = WAIT_LO;
            end else if (cnt_reg == TO_LAST) begin
               timeout_next = 1'b1;
               cnt_next     = '0;
               state_next   = GAP;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         WAIT_LO: begin
            if (!busy_s) begin
               rd_strobe_next = ~STROBE_IDLE;
               cnt_next       = '0;
               state_next     = READ;
            end else if (cnt_reg == TO_LAST) begin
               timeout_next = 1'b1;
               cnt_next     = '0;
               state_next   = GAP;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         READ: begin
            if (cnt_reg == RD_LAST) begin
               // Bus is still driven during the last low cycle, so capture on this edge
               rd_strobe_next = STROBE_IDLE;
               data_next      = D_in;
               led_next       = D_in;
               data_ch_next   = ab_reg;
               valid_next     = 1'b1;
               cnt_next       = '0;
               state_next     = GAP;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_reg == GAP_LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            convst_n_next  = STROBE_IDLE;
            rd_strobe_next = STROBE_IDLE;
            cnt_next       = '0;
            state_next     = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any transaction in flight without a valid
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         convst_n_reg  <= STROBE_IDLE;
         rd_strobe_reg <= STROBE_IDLE;
         ab_reg        <= 1'b0;
         data_reg      <= '0;
         data_ch_reg   <= 1'b0;
         valid_reg     <= 1'b0;
         timeout_reg   <= 1'b0;
         led_reg       <= DATA_W'(LED_RST_PATTERN);
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         convst_n_reg  <= convst_n_next;
         rd_strobe_reg <= rd_strobe_next;
         ab_reg        <= ab_next;
         data_reg      <= data_next;
         data_ch_reg   <= data_ch_next;
         valid_reg     <= valid_next;
         timeout_reg   <= timeout_next;
         led_reg       <= led_next;
      end
   end

   // CS_n and RD_n always move together, so one register drives both pins
   assign CONVST_n    = convst_n_reg;
   assign CS_n        = rd_strobe_reg;
   assign RD_n        = rd_strobe_reg;
   assign AB          = ab_reg;
   assign data        = data_reg;
   assign data_ch     = data_ch_reg;
   assign valid       = valid_reg;
   assign timeout_err = timeout_reg;
   assign LED         = led_reg;

endmodule

// File: tb/tb_adc_reader.sv
// Self-checking bench for adc_reader: behavioural ADC model, negedge bus monitor,
// and one directed/randomized stimulus sequence.
module tb_adc_reader;

   logic       clk = 1'b0;
   logic       rst, start, auto_en, ch_sel;
   logic       AB, CONVST_n, CS_n, RD_n, BUSY;
   logic [7:0] D_in, data, LED;
   logic       data_ch, valid, timeout_err;

   always #5 clk = ~clk;

   adc_reader #(
      .DATA_W(8), .CONV_LOW_CYC(4), .RD_CYC(6), .GAP_CYC(20), .TIMEOUT_CYC(250), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .ch_sel(ch_sel),
      .AB(AB), .CONVST_n(CONVST_n), .CS_n(CS_n), .RD_n(RD_n), .BUSY(BUSY),
      .D_in(D_in), .data(data), .data_ch(data_ch), .valid(valid),
      .timeout_err(timeout_err), .LED(LED)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- ADC model ----------------
   // Per conversion k: BUSY rises d_tab[k] clocks after CONVST falls and stays high
   // l_tab[k] clocks; samp_tab[k] is on the bus while RD_n is low, its complement otherwise.
   logic [7:0] samp_tab [64];
   int         d_tab [64];
   int         l_tab [64];
   logic       busy_dead = 1'b0;
   int         mdl_cnt = 0;
   logic [7:0] cur_sample = 8'h00;

   initial begin : adc_model
      int k;
      BUSY = 1'b0;
      forever begin
         @(negedge CONVST_n);
         k = mdl_cnt % 64;
         mdl_cnt++;
         cur_sample = samp_tab[k];
         if (!busy_dead) begin
            repeat (d_tab[k]) @(posedge clk);
            #1 BUSY = 1'b1;
            repeat (l_tab[k]) @(posedge clk);
            #1 BUSY = 1'b0;
         end
      end
   end

   assign D_in = RD_n ? ~cur_sample : cur_sample;

   // ---------------- bus monitor ----------------
   typedef struct {
      logic [7:0] d;
      logic       ch;
      logic [7:0] led;
      logic [7:0] exp_d;
      logic       exp_ch;
      int         cyc;
   } vrec_t;

   vrec_t val_q[$];
   int conv_fall_q[$], conv_rise_q[$], conv_w_q[$], rd_w_q[$], rd_fall_q[$], to_q[$];
   int cyc = 0, conv_run = 0, rd_run = 0, busy_low_run = 0;
   int rd_bad = 0, ab_bad = 0, csrd_bad = 0, val_wide = 0;
   logic prev_convst = 1'b1, prev_rd = 1'b1, prev_ab = 1'b0, prev_valid = 1'b0;
   logic prev_ch_sel = 1'b0, conv_ch = 1'b0;
   logic [7:0] last_rd_d = 8'h00;

   // Sample the bus on the falling edge and log pulse widths, captures and violations
   always @(negedge clk) begin
      cyc          <= cyc + 1;
      prev_convst  <= CONVST_n;
      prev_rd      <= RD_n;
      prev_ab      <= AB;
      prev_valid   <= valid;
      prev_ch_sel  <= ch_sel;
      busy_low_run <= BUSY ? 0 : busy_low_run + 1;
      if (!rst) begin
         if (CONVST_n === 1'b0) begin
            conv_run <= (prev_convst === 1'b1) ? 1 : conv_run + 1;
            if (prev_convst === 1'b1) begin
               conv_fall_q.push_back(cyc);
               conv_ch <= prev_ch_sel;
            end
         end else if (prev_convst === 1'b0) begin
            conv_w_q.push_back(conv_run);
            conv_rise_q.push_back(cyc);
         end
         if (RD_n === 1'b0) begin
            rd_run    <= (prev_rd === 1'b1) ? 1 : rd_run + 1;
            last_rd_d <= D_in;
            if (prev_rd === 1'b1) rd_fall_q.push_back(cyc);
            if (BUSY === 1'b1 || (prev_rd === 1'b1 && busy_low_run < 3)) rd_bad <= rd_bad + 1;
         end else if (prev_rd === 1'b0) begin
            rd_w_q.push_back(rd_run);
         end
         if (CS_n !== RD_n) csrd_bad <= csrd_bad + 1;
         if (AB !== prev_ab && (prev_convst === 1'b0 || prev_rd === 1'b0 || RD_n === 1'b0))
            ab_bad <= ab_bad + 1;
         if (valid === 1'b1) begin
            val_q.push_back('{d: data, ch: data_ch, led: LED, exp_d: last_rd_d,
                              exp_ch: conv_ch, cyc: cyc});
            if (prev_valid === 1'b1) val_wide <= val_wide + 1;
         end
         if (timeout_err === 1'b1) to_q.push_back(cyc);
      end
   end

   function automatic int qsize(input int sel);
      case (sel)
         0:       return val_q.size();
         1:       return conv_fall_q.size();
         2:       return to_q.size();
         default: return conv_rise_q.size();
      endcase
   endfunction

   // Bounded wait for a monitor log to reach a given length
   task automatic wait_cnt(input int sel, input int target, input int budget, input string tag);
      int n;
      int cur;
      n = 0;
      cur = qsize(sel);
      while (cur < target && n < budget) begin
         tick(1);
         n++;
         cur = qsize(sel);
      end
      chk(tag, cur, target);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int idx, n_val, n_fall, n_rise, n_to, n_rd, n;
      logic c;
      for (int i = 0; i < 64; i++) begin
         samp_tab[i] = 8'($urandom);
         d_tab[i]    = $urandom_range(2, 5);
         l_tab[i]    = $urandom_range(3, 40);
      end
      rst = 1'b1; start = 1'b0; auto_en = 1'b0; ch_sel = 1'b0;
      tick(3);
      chk("rst_convst", 32'(CONVST_n), 1);
      chk("rst_cs", 32'(CS_n), 1);
      chk("rst_rd", 32'(RD_n), 1);
      chk("rst_ab", 32'(AB), 0);
      chk("rst_data", 32'(data), 0);
      chk("rst_data_ch", 32'(data_ch), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      chk("rst_led", 32'(LED), 'h55);
      rst = 1'b0;
      tick(2);

      // Single conversion, channel 1, sample A7
      idx = mdl_cnt % 64;
      samp_tab[idx] = 8'hA7; d_tab[idx] = 3; l_tab[idx] = 30;
      n_val = val_q.size(); n_fall = conv_fall_q.size();
      ch_sel = 1'b1; start = 1'b1;
      tick(1);
      start = 1'b0; ch_sel = 1'b0;
      wait_cnt(0, n_val + 1, 200, "single_valid_wait");
      if (val_q.size() > n_val) begin
         chk("single_data", 32'(val_q[n_val].d), 'hA7);
         chk("single_ch", 32'(val_q[n_val].ch), 1);
         chk("single_led", 32'(val_q[n_val].led), 'hA7);
         chk("single_latency", val_q[n_val].cyc - conv_fall_q[n_fall], 3 + 30 + 9);
      end
      chk("single_ab", 32'(AB), 1);
      chk("single_convst_w", conv_w_q[conv_w_q.size() - 1], 4);
      chk("single_rd_w", rd_w_q[rd_w_q.size() - 1], 6);
      tick(5);
      chk("single_valid_count", val_q.size() - n_val, 1);
      chk("single_valid_width", val_wide, 0);
      chk("single_rd_after_busy", rd_bad, 0);
      tick(25);

      // Free-running with ch_sel toggling every 10 clocks
      idx = mdl_cnt % 64;
      samp_tab[idx] = 8'h10; samp_tab[(idx + 1) % 64] = 8'h20; samp_tab[(idx + 2) % 64] = 8'h30;
      n_val = val_q.size(); n_fall = conv_fall_q.size();
      auto_en = 1'b1;
      for (int k = 0; k < 1000 && val_q.size() < n_val + 3; k++) begin
         if (k % 10 == 0) ch_sel = ~ch_sel;
         tick(1);
      end
      auto_en = 1'b0;
      chk("auto_valid_count", val_q.size() - n_val, 3);
      for (int j = 0; j < 3; j++) begin
         if (val_q.size() > n_val + j) begin
            chk($sformatf("auto_data%0d", j), 32'(val_q[n_val + j].d), 'h10 * (j + 1));
            chk($sformatf("auto_led%0d", j), 32'(val_q[n_val + j].led), 'h10 * (j + 1));
            chk($sformatf("auto_ch%0d", j), 32'(val_q[n_val + j].ch), 32'(val_q[n_val + j].exp_ch));
         end
      end
      for (int j = 0; j < 2; j++) begin
         if (conv_fall_q.size() > n_fall + j + 1)
            chk($sformatf("auto_period%0d", j),
                conv_fall_q[n_fall + j + 1] - conv_fall_q[n_fall + j],
                d_tab[(idx + j) % 64] + l_tab[(idx + j) % 64] + 30);
      end
      chk("auto_ab_stable", ab_bad, 0);
      tick(25);

      // BUSY never rises: two back-to-back timeouts under auto_en
      busy_dead = 1'b1;
      n_to = to_q.size(); n_rise = conv_rise_q.size(); n_fall = conv_fall_q.size();
      n_val = val_q.size(); n_rd = rd_fall_q.size();
      auto_en = 1'b1;
      wait_cnt(2, n_to + 1, 400, "to_wait");
      wait_cnt(1, n_fall + 2, 100, "to_refire_wait");
      auto_en = 1'b0;
      if (to_q.size() > n_to && conv_rise_q.size() > n_rise)
         chk("to_delay", to_q[n_to] - conv_rise_q[n_rise], 250);
      if (to_q.size() > n_to && conv_fall_q.size() > n_fall + 1)
         chk("to_gap", conv_fall_q[n_fall + 1] - to_q[n_to], 21);
      wait_cnt(2, n_to + 2, 400, "to_second_wait");
      tick(25);
      chk("to_pulse_count", to_q.size() - n_to, 2);
      if (to_q.size() > n_to + 1)
         chk("to_spacing", to_q[n_to + 1] - to_q[n_to], 21 + 4 + 250);
      chk("to_no_valid", val_q.size() - n_val, 0);
      chk("to_no_rd", rd_fall_q.size() - n_rd, 0);
      chk("to_data_kept", 32'(data), 'h30);
      busy_dead = 1'b0;
      tick(5);

      // Reset in the third READ cycle, then a clean conversion
      n_val = val_q.size();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n = 0;
      while (RD_n !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("rstmid_rd_seen", 32'(RD_n), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_cs", 32'(CS_n), 1);
      chk("rstmid_rd", 32'(RD_n), 1);
      chk("rstmid_convst", 32'(CONVST_n), 1);
      chk("rstmid_data", 32'(data), 0);
      chk("rstmid_led", 32'(LED), 'h55);
      chk("rstmid_valid", 32'(valid), 0);
      tick(1);
      rst = 1'b0;
      tick(3);
      chk("rstmid_no_valid", val_q.size() - n_val, 0);
      idx = mdl_cnt % 64;
      ch_sel = 1'b1; start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_cnt(0, n_val + 1, 200, "rstmid_after_wait");
      if (val_q.size() > n_val) begin
         chk("rstmid_after_data", 32'(val_q[n_val].d), 32'(samp_tab[idx]));
         chk("rstmid_after_ch", 32'(val_q[n_val].ch), 1);
      end
      tick(25);

      // start during WAIT_LO is dropped
      idx = mdl_cnt % 64;
      d_tab[idx] = 3; l_tab[idx] = 30;
      n_val = val_q.size(); n_fall = conv_fall_q.size(); n_rise = conv_rise_q.size();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_cnt(3, n_rise + 1, 50, "drop_rise_wait");
      tick(10);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_cnt(0, n_val + 1, 200, "drop_valid_wait");
      tick(40);
      chk("drop_conv_count", conv_fall_q.size() - n_fall, 1);
      chk("drop_valid_count", val_q.size() - n_val, 1);

      // start and auto_en together for one IDLE cycle launch one conversion
      n_val = val_q.size(); n_fall = conv_fall_q.size();
      start = 1'b1; auto_en = 1'b1;
      tick(1);
      start = 1'b0; auto_en = 1'b0;
      wait_cnt(0, n_val + 1, 200, "both_valid_wait");
      tick(30);
      chk("both_conv_count", conv_fall_q.size() - n_fall, 1);
      chk("both_valid_count", val_q.size() - n_val, 1);

      // Randomized single conversions; ch_sel flips right after launch
      for (int r = 0; r < 6; r++) begin
         idx = mdl_cnt % 64;
         n_val = val_q.size();
         c = 1'($urandom_range(0, 1));
         ch_sel = c; start = 1'b1;
         tick(1);
         start = 1'b0; ch_sel = ~c;
         wait_cnt(0, n_val + 1, 200, $sformatf("rand%0d_wait", r));
         if (val_q.size() > n_val) begin
            chk($sformatf("rand%0d_data", r), 32'(val_q[n_val].d), 32'(samp_tab[idx]));
            chk($sformatf("rand%0d_led", r), 32'(val_q[n_val].led), 32'(samp_tab[idx]));
            chk($sformatf("rand%0d_ch", r), 32'(val_q[n_val].ch), 32'(c));
         end
         chk($sformatf("rand%0d_rd_w", r), rd_w_q[rd_w_q.size() - 1], 6);
         chk($sformatf("rand%0d_convst_w", r), conv_w_q[conv_w_q.size() - 1], 4);
         tick(25);
      end

      chk("final_ab_stable", ab_bad, 0);
      chk("final_cs_eq_rd", csrd_bad, 0);
      chk("final_rd_after_busy", rd_bad, 0);
      chk("final_valid_width", val_wide, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
